// File: rtl/gb_bus_pkg.sv
// +----------------------------------------------------------------------+
// | gb_bus_pkg : shared types and constants for the Game Boy bus arbiter |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package gb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  localparam int CPU  = 0;
  localparam int DMA  = 1;
  localparam int HDMA = 2;

  // Index arithmetic modulo n for base in [0,n) and step in [0,n].
  function automatic int wrap_idx(input int base, input int step, input int n);
    int s;
    s = base + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gb_arb_select.sv
// +----------------------------------------------------------------------+
// | gb_arb_select : winner selection, fixed priority or round-robin      |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module gb_arb_select
  import gb_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  input  logic                   rr_mode,
  output logic [ID_W-1:0]        winner,
  output logic                   valid
);

  always_comb begin
    winner = '0;
    valid  = |req;
    if (rr_mode) begin
      // Walk downward so the last hit is the nearest index above ptr.
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        int idx;
        idx = wrap_idx(int'(ptr), k, NUM_MASTERS);
        if (req[idx]) winner = ID_W'(idx);
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) winner = ID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gb_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | gb_bus_arbiter : N-master to 1-slave bus arbiter with slave timeout  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module gb_bus_arbiter
  import gb_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                          busy,
  output logic                          slv_req,
  output logic                          slv_we,
  output logic [ADDR_W-1:0]             slv_addr,
  output logic [DATA_W-1:0]             slv_wdata,
  input  logic                          slv_ack,
  input  logic [DATA_W-1:0]             slv_rdata
);

  localparam int ID_W  = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  w_winner;
  logic             w_valid;
  logic             w_timeout;

  gb_arb_select #(
    .NUM_MASTERS(NUM_MASTERS),
    .ID_W       (ID_W)
  ) u_select (
    .req    (m_req),
    .ptr    (r_ptr),
    .rr_mode(RR_MODE != 0),
    .winner (w_winner),
    .valid  (w_valid)
  );

  // Counter holds the number of ISSUE cycles already spent before this one.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= ID_W'(NUM_MASTERS - 1);
      r_cnt     <= '0;
      m_ack     <= '0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      slv_req   <= 1'b0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      m_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            slv_we    <= m_we[w_winner];
            slv_addr  <= m_addr[int'(w_winner)*ADDR_W +: ADDR_W];
            slv_wdata <= m_wdata[int'(w_winner)*DATA_W +: DATA_W];
            grant_id  <= w_winner;
            slv_req   <= 1'b1;
            busy      <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          // A real ack beats a coincident timeout.
          if (slv_ack || w_timeout) begin
            if (slv_ack) begin
              m_rdata <= slv_we ? '0 : slv_rdata;
              m_err   <= 1'b0;
            end else begin
              m_rdata <= {DATA_W{1'b1}};
              m_err   <= 1'b1;
            end
            slv_req <= 1'b0;
            m_ack   <= NUM_MASTERS'(1) << grant_id;
            r_ptr   <= grant_id;
            r_state <= DONE;
          end
        end
        DONE: begin
          m_err   <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gb_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_gb_bus_arbiter : fixed-priority and round-robin arbiter bench     |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gb_bus_arbiter;

  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_i   [2];
  logic           sack_i  [2];
  logic [N-1:0]   we_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [DW-1:0]  srdata_i;

  logic [N-1:0]   ack_o   [2];
  logic           err_o   [2];
  logic [DW-1:0]  rdata_o [2];
  logic [1:0]     gid_o   [2];
  logic           busy_o  [2];
  logic           sreq_o  [2];
  logic           swe_o   [2];
  logic [AW-1:0]  saddr_o [2];
  logic [DW-1:0]  swdata_o[2];

  gb_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TMO)) dut_fp (
    .clock(clk), .reset(rst), .m_req(req_i[0]), .m_we(we_i), .m_addr(addr_i), .m_wdata(wdata_i),
    .m_ack(ack_o[0]), .m_err(err_o[0]), .m_rdata(rdata_o[0]), .grant_id(gid_o[0]), .busy(busy_o[0]),
    .slv_req(sreq_o[0]), .slv_we(swe_o[0]), .slv_addr(saddr_o[0]), .slv_wdata(swdata_o[0]),
    .slv_ack(sack_i[0]), .slv_rdata(srdata_i));

  gb_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TMO)) dut_rr (
    .clock(clk), .reset(rst), .m_req(req_i[1]), .m_we(we_i), .m_addr(addr_i), .m_wdata(wdata_i),
    .m_ack(ack_o[1]), .m_err(err_o[1]), .m_rdata(rdata_o[1]), .grant_id(gid_o[1]), .busy(busy_o[1]),
    .slv_req(sreq_o[1]), .slv_we(swe_o[1]), .slv_addr(saddr_o[1]), .slv_wdata(swdata_o[1]),
    .slv_ack(sack_i[1]), .slv_rdata(srdata_i));

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, inst, act, exp);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  int             cyc = 0;
  int             phase   [2];  // 0 idle, 1 slave access pending, 2 ack cycle
  int             waited  [2];  // cycles the slave access has been outstanding
  int             ptr     [2];
  logic [N-1:0]   e_ack   [2];
  logic           e_err   [2];
  logic [DW-1:0]  e_rdata [2];
  logic [1:0]     e_gid   [2];
  logic           e_busy  [2];
  logic           e_sreq  [2];
  logic           e_we    [2];
  logic [AW-1:0]  e_addr  [2];
  logic [DW-1:0]  e_wdata [2];

  function automatic int pick(input logic [N-1:0] r, input int p, input bit rr);
    int w = -1;
    if (!rr) begin
      for (int i = 0; i < N; i++) if (r[i] && w < 0) w = i;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(p + k) % N] && w < 0) w = (p + k) % N;
    end
    return w;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        phase[i] = 0; waited[i] = 0; ptr[i] = N - 1;
        e_ack[i] = '0; e_err[i] = 0; e_rdata[i] = '0; e_gid[i] = '0;
        e_busy[i] = 0; e_sreq[i] = 0; e_we[i] = 0; e_addr[i] = '0; e_wdata[i] = '0;
      end else begin
        e_ack[i] = '0;
        if (phase[i] == 2) begin
          phase[i] = 0; e_busy[i] = 0; e_err[i] = 0;
        end else if (phase[i] == 1) begin
          waited[i]++;
          if (sack_i[i] || waited[i] == TMO) begin
            e_err[i]   = !sack_i[i];
            e_rdata[i] = !sack_i[i] ? 8'hFF : (e_we[i] ? 8'h00 : srdata_i);
            e_sreq[i]  = 0;
            e_ack[i]   = N'(1) << e_gid[i];
            ptr[i]     = int'(e_gid[i]);
            phase[i]   = 2;
          end
        end else if (req_i[i] != '0) begin
          int g;
          g = pick(req_i[i], ptr[i], i == 1);
          e_gid[i]   = 2'(g);
          e_we[i]    = we_i[g];
          e_addr[i]  = addr_i[g*AW +: AW];
          e_wdata[i] = wdata_i[g*DW +: DW];
          e_sreq[i]  = 1; e_busy[i] = 1; waited[i] = 0; phase[i] = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk(i, "slv_req", 32'(sreq_o[i]), 32'(e_sreq[i]));
        chk(i, "busy", 32'(busy_o[i]), 32'(e_busy[i]));
        chk(i, "m_ack", 32'(ack_o[i]), 32'(e_ack[i]));
        chk(i, "m_err", 32'(err_o[i]), 32'(e_err[i]));
        chk(i, "grant_id", 32'(gid_o[i]), 32'(e_gid[i]));
        if (e_sreq[i]) begin
          chk(i, "slv_addr", 32'(saddr_o[i]), 32'(e_addr[i]));
          chk(i, "slv_we", 32'(swe_o[i]), 32'(e_we[i]));
          chk(i, "slv_wdata", 32'(swdata_o[i]), 32'(e_wdata[i]));
        end
        if (e_ack[i] != '0) chk(i, "m_rdata", 32'(rdata_o[i]), 32'(e_rdata[i]));
      end
    end
  end

  // ---------------- stimulus, slave and ack recorder ----------------
  typedef struct { int inst; int id; int cyc; logic err; logic [DW-1:0] rd; } rec_t;
  rec_t recq[$];
  int   ack_wait [2];
  int   scnt     [2];
  int   sreq_cnt [2];
  bit   auto_drop[2];
  int   t0;

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = (r < 0) ? i : 99;
    return r;
  endfunction

  function automatic int nrec(input int inst);
    int c = 0;
    foreach (recq[k]) if (recq[k].inst == inst) c++;
    return c;
  endfunction

  function automatic rec_t getrec(input int inst, input int n);
    rec_t r = '{inst: -1, id: -1, cyc: -1, err: 1'bx, rd: 'x};
    int c = 0;
    foreach (recq[k]) if (recq[k].inst == inst) begin
      if (c == n) r = recq[k];
      c++;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ack_o[i] != '0)
        recq.push_back('{inst: i, id: oh2i(ack_o[i]), cyc: cyc, err: err_o[i], rd: rdata_o[i]});
      if (sreq_o[i]) sreq_cnt[i]++;
      if (auto_drop[i]) req_i[i] = req_i[i] & ~e_ack[i];
      if (sreq_o[i]) begin
        sack_i[i] = (scnt[i] == ack_wait[i]);
        scnt[i]++;
      end else begin
        sack_i[i] = 1'b0;
        scnt[i]   = 0;
      end
    end
  endtask

  task automatic wait_acks(input int inst, input int n, input int lim);
    int k = 0;
    while (nrec(inst) < n && k < lim) begin
      tick();
      k++;
    end
    if (nrec(inst) < n) begin
      tests++; fails++;
      $display("FAIL ack_wait[%0d]: got %0d acks, expected %0d", inst, nrec(inst), n);
    end
  endtask

  initial begin
    rst = 1'b1;
    we_i = '0;
    addr_i  = {16'hC000, 16'h1234, 16'hFF44};
    wdata_i = {8'h5A, 8'h22, 8'h11};
    srdata_i = 8'h90;
    for (int i = 0; i < 2; i++) begin
      req_i[i] = '0; ack_wait[i] = 0; scnt[i] = 0; sreq_cnt[i] = 0; auto_drop[i] = 1;
    end
    tick();
    chk_en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst slv_req", 32'(sreq_o[i]), 0);
      chk(i, "rst busy", 32'(busy_o[i]), 0);
      chk(i, "rst m_ack", 32'(ack_o[i]), 0);
      chk(i, "rst grant_id", 32'(gid_o[i]), 0);
    end
    rst = 1'b0;
    tick();

    // Contention 3'b110: master 1 acked in cycle 2, master 2 in cycle 5.
    recq.delete();
    req_i[0] = 3'b110; req_i[1] = 3'b110; t0 = cyc;
    wait_acks(0, 2, 20);
    for (int i = 0; i < 2; i++) begin
      chk(i, "cont id0", 32'(getrec(i, 0).id), 1);
      chk(i, "cont cyc0", 32'(getrec(i, 0).cyc - t0), 2);
      chk(i, "cont id1", 32'(getrec(i, 1).id), 2);
      chk(i, "cont cyc1", 32'(getrec(i, 1).cyc - t0), 5);
    end
    repeat (3) tick();

    // Round-robin with all masters requesting continuously.
    recq.delete();
    auto_drop[1] = 0;
    req_i[1] = 3'b111;
    wait_acks(1, 6, 60);
    req_i[1] = '0;
    auto_drop[1] = 1;
    for (int k = 0; k < 6; k++) begin
      chk(1, "rr order", 32'(getrec(1, k).id), 32'(k % 3));
      if (k > 0) chk(1, "rr spacing", 32'(getrec(1, k).cyc - getrec(1, k - 1).cyc), 3);
    end
    repeat (3) tick();

    // Read with 4 wait cycles.
    recq.delete();
    ack_wait[0] = 4; srdata_i = 8'h90; we_i = '0;
    req_i[0] = 3'b001; t0 = cyc;
    tick();
    chk(0, "rd slv_addr", 32'(saddr_o[0]), 32'h0000FF44);
    wait_acks(0, 1, 20);
    chk(0, "rd id", 32'(getrec(0, 0).id), 0);
    chk(0, "rd data", 32'(getrec(0, 0).rd), 32'h90);
    chk(0, "rd err", 32'(getrec(0, 0).err), 0);
    chk(0, "rd latency", 32'(getrec(0, 0).cyc - t0), 6);
    repeat (3) tick();

    // Timeout on master 0, then master 1 served normally.
    recq.delete();
    sreq_cnt[0] = 0; ack_wait[0] = -1;
    req_i[0] = 3'b011;
    wait_acks(0, 1, 40);
    chk(0, "tmo slv_req cycles", 32'(sreq_cnt[0]), 15);
    chk(0, "tmo id", 32'(getrec(0, 0).id), 0);
    chk(0, "tmo err", 32'(getrec(0, 0).err), 1);
    chk(0, "tmo data", 32'(getrec(0, 0).rd), 32'hFF);
    ack_wait[0] = 0;
    wait_acks(0, 2, 20);
    chk(0, "post-tmo id", 32'(getrec(0, 1).id), 1);
    chk(0, "post-tmo err", 32'(getrec(0, 1).err), 0);
    chk(0, "post-tmo data", 32'(getrec(0, 1).rd), 32'h90);
    repeat (3) tick();

    // Park the RR pointer on master 0, then reset in the second ISSUE cycle.
    recq.delete();
    req_i[1] = 3'b001;
    wait_acks(1, 1, 20);
    repeat (3) tick();
    recq.delete();
    ack_wait[0] = -1; ack_wait[1] = -1;
    req_i[0] = 3'b100; req_i[1] = 3'b100;
    tick();
    tick();
    chk(1, "pre-rst slv_req", 32'(sreq_o[1]), 1);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "midrst slv_req", 32'(sreq_o[i]), 0);
      chk(i, "midrst busy", 32'(busy_o[i]), 0);
      chk(i, "midrst m_ack", 32'(ack_o[i]), 0);
    end
    rst = 1'b0;
    ack_wait[0] = 0; ack_wait[1] = 0;
    req_i[0] = 3'b111; req_i[1] = 3'b111;
    wait_acks(1, 3, 30);
    wait_acks(0, 3, 30);
    for (int k = 0; k < 3; k++) chk(1, "post-rst rr id", 32'(getrec(1, k).id), 32'(k));
    chk(0, "post-rst fp id", 32'(getrec(0, 0).id), 0);
    repeat (3) tick();

    // Write from master 2 with the ack landing on the timeout cycle.
    recq.delete();
    ack_wait[0] = TMO - 1; we_i = 3'b100;
    req_i[0] = 3'b100; t0 = cyc;
    tick();
    chk(0, "wr slv_wdata", 32'(swdata_o[0]), 32'h5A);
    chk(0, "wr slv_we", 32'(swe_o[0]), 1);
    chk(0, "wr slv_addr", 32'(saddr_o[0]), 32'h0000C000);
    wait_acks(0, 1, 30);
    chk(0, "wr id", 32'(getrec(0, 0).id), 2);
    chk(0, "wr err", 32'(getrec(0, 0).err), 0);
    chk(0, "wr data", 32'(getrec(0, 0).rd), 0);
    chk(0, "wr latency", 32'(getrec(0, 0).cyc - t0), 16);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
